rv_exec_datapath: RTL and testbench

Execute-stage datapath slice for the single-cycle RV32 core. It bundles three pieces:
- a 32x32 integer register file (x0 hardwired to zero, two combinational read ports, one synchronous write port);
- a combinational one-hot-controlled ALU;
- a 3-to-8 one-hot decoder for funct3.

The core's decode logic drives the register addresses, ALU operands and ALU op; the write-back mux feeds wdata.

---
 rtl/rv_exec_pkg.sv | 19 +
 rtl/rv_exec_datapath_if.sv | 25 ++
 rtl/rv_regfile.sv | 30 +++
 rtl/rv_exec_datapath.sv | 40 ++++
 tb/tb_rv_exec_datapath.sv | 103 ++++++++++
 5 files changed

// File: rtl/rv_exec_pkg.sv
// rv_exec_pkg: shared widths and one-hot ALU op bit positions for the execute datapath
package rv_exec_pkg;
  localparam int XLEN = 32;
  localparam int NREG_LOG2 = 5;
  localparam int NREG = 1 << NREG_LOG2;
  localparam int ALU_OP_W = 10;
  localparam int SHAMT_W = 5;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR = 3;
  localparam int ALU_XOR = 4;
  localparam int ALU_SLL = 5;
  localparam int ALU_SRL = 6;
  localparam int ALU_SRA = 7;
  localparam int ALU_SLT = 8;
  localparam int ALU_SLTU = 9;
  typedef logic [ALU_OP_W-1:0] alu_op_t;
endpackage

// File: rtl/rv_exec_datapath_if.sv
// rv_exec_datapath_if: register file, ALU and funct3 decode signals between decode and execute
interface rv_exec_datapath_if;
  import rv_exec_pkg::*;
  logic wen;
  logic [NREG_LOG2-1:0] waddr;
  logic [XLEN-1:0] wdata;
  logic [NREG_LOG2-1:0] raddr1;
  logic [XLEN-1:0] rdata1;
  logic [NREG_LOG2-1:0] raddr2;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  alu_op_t alu_op;
  logic [XLEN-1:0] alu_result;
  logic [2:0] funct3;
  logic [7:0] funct3_d;
  modport master (
    output wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, funct3,
    input rdata1, rdata2, alu_result, funct3_d
  );
  modport slave (
    input wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, funct3,
    output rdata1, rdata2, alu_result, funct3_d
  );
endinterface

// File: rtl/rv_regfile.sv
// rv_regfile: 32xXLEN register file, x0 reads zero, async clear; REGFILE_BYPASS_EN adds write-through reads
module rv_regfile
  import rv_exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen_i,
  input  logic [NREG_LOG2-1:0] waddr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [NREG_LOG2-1:0] raddr1_i,
  output logic [XLEN-1:0]      rdata1_o,
  input  logic [NREG_LOG2-1:0] raddr2_i,
  output logic [XLEN-1:0]      rdata2_o
);
  logic [XLEN-1:0] regs_q [NREG];
  logic fwd1, fwd2;
`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wen_i && waddr_i != '0 && raddr1_i == waddr_i;
  assign fwd2 = wen_i && waddr_i != '0 && raddr2_i == waddr_i;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  // Clear everything on reset; otherwise commit writes to any register except x0
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (wen_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  assign rdata1_o = raddr1_i == '0 ? '0 : fwd1 ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = raddr2_i == '0 ? '0 : fwd2 ? wdata_i : regs_q[raddr2_i];
endmodule

// File: rtl/rv_exec_datapath.sv
// rv_exec_datapath: execute slice with register file, one-hot ALU and funct3 one-hot decoder
module rv_exec_datapath
  import rv_exec_pkg::*;
(
  input logic clk,
  input logic reset,
  rv_exec_datapath_if.slave bus
);
  logic [XLEN-1:0] a, b;
  alu_op_t op;
  logic [SHAMT_W-1:0] sh;
  assign a = bus.alu_src1;
  assign b = bus.alu_src2;
  assign op = bus.alu_op;
  assign sh = b[SHAMT_W-1:0];
  rv_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wen_i    (bus.wen),
    .waddr_i  (bus.waddr),
    .wdata_i  (bus.wdata),
    .raddr1_i (bus.raddr1),
    .rdata1_o (bus.rdata1),
    .raddr2_i (bus.raddr2),
    .rdata2_o (bus.rdata2)
  );
  // Every selected sub-result is ORed in, so no op gives 0 and several ops merge
  always_comb
    bus.alu_result = ({XLEN{op[ALU_ADD]}} & (a + b))
                   | ({XLEN{op[ALU_SUB]}} & (a - b))
                   | ({XLEN{op[ALU_AND]}} & (a & b))
                   | ({XLEN{op[ALU_OR]}} & (a | b))
                   | ({XLEN{op[ALU_XOR]}} & (a ^ b))
                   | ({XLEN{op[ALU_SLL]}} & (a << sh))
                   | ({XLEN{op[ALU_SRL]}} & (a >> sh))
                   | ({XLEN{op[ALU_SRA]}} & XLEN'($signed(a) >>> sh))
                   | ({XLEN{op[ALU_SLT]}} & XLEN'($signed(a) < $signed(b)))
                   | ({XLEN{op[ALU_SLTU]}} & XLEN'(a < b));
  assign bus.funct3_d = 8'b1 << bus.funct3;
endmodule

// File: tb/tb_rv_exec_datapath.sv
// tb_rv_exec_datapath: directed checks of register file, ALU and funct3 decoder
module tb_rv_exec_datapath;
  logic clk, reset;
  int errors = 0;
  int checks = 0;
  rv_exec_datapath_if dp_if ();
  rv_exec_datapath dut (.clk(clk), .reset(reset), .bus(dp_if));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12] = '{
    '{10'h001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{10'h002, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
    '{10'h080, 32'h80000000, 32'h00000024, 32'hF8000000},
    '{10'h040, 32'h80000000, 32'h00000024, 32'h08000000},
    '{10'h100, 32'h80000000, 32'h00000001, 32'h00000001},
    '{10'h200, 32'h80000000, 32'h00000001, 32'h00000000},
    '{10'h000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000},
    '{10'h00C, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0},
    '{10'h010, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F},
    '{10'h020, 32'h00000001, 32'h0000003F, 32'h80000000},
    '{10'h001, 32'h00000005, 32'h00000007, 32'h0000000C},
    '{10'h003, 32'h0000000A, 32'h00000003, 32'h0000000F}
  };
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    dp_if.wen = 1'b1;
    dp_if.waddr = addr;
    dp_if.wdata = data;
    @(posedge clk);
    #1 dp_if.wen = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    dp_if.wen = 1'b0;
    dp_if.waddr = '0;
    dp_if.wdata = '0;
    dp_if.raddr1 = 5'd5;
    dp_if.raddr2 = 5'd0;
    dp_if.alu_src1 = '0;
    dp_if.alu_src2 = '0;
    dp_if.alu_op = '0;
    dp_if.funct3 = '0;
    repeat (2) @(posedge clk);
    #1 check("rst_x5", dp_if.rdata1, 32'h0);
    check("rst_x0", dp_if.rdata2, 32'h0);
    @(negedge clk) reset = 1'b0;
    wr(5'd5, 32'h12345678);
    #1 check("wr_x5", dp_if.rdata1, 32'h12345678);
    reset = 1'b1;
    #1 check("async_rst", dp_if.rdata1, 32'h0);
    reset = 1'b0;
    wr(5'd3, 32'hDEADBEEF);
    dp_if.raddr1 = 5'd3;
    #1 check("wr_x3", dp_if.rdata1, 32'hDEADBEEF);
    wr(5'd0, 32'hFFFFFFFF);
    dp_if.raddr2 = 5'd0;
    #1 check("wr_x0", dp_if.rdata2, 32'h0);
    @(negedge clk);
    dp_if.wen = 1'b1;
    dp_if.waddr = 5'd3;
    dp_if.wdata = 32'h1;
    dp_if.raddr1 = 5'd3;
    dp_if.raddr2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cyc_p1", dp_if.rdata1, 32'h1);
    check("same_cyc_p2", dp_if.rdata2, 32'h1);
`else
    check("same_cyc_p1", dp_if.rdata1, 32'hDEADBEEF);
    check("same_cyc_p2", dp_if.rdata2, 32'hDEADBEEF);
`endif
    @(posedge clk);
    #1 dp_if.wen = 1'b0;
    #1 check("after_wr_p1", dp_if.rdata1, 32'h1);
    check("after_wr_p2", dp_if.rdata2, 32'h1);
    for (int i = 0; i < 12; i++) begin
      dp_if.alu_op = vecs[i].op;
      dp_if.alu_src1 = vecs[i].a;
      dp_if.alu_src2 = vecs[i].b;
      #1 check($sformatf("alu%0d", i), dp_if.alu_result, vecs[i].exp);
    end
    for (int i = 0; i < 8; i++) begin
      dp_if.funct3 = 3'(i);
      #1 check($sformatf("dec%0d", i), {24'h0, dp_if.funct3_d}, 32'h1 << i);
      check($sformatf("dec%0d_ones", i), 32'($countones(dp_if.funct3_d)), 32'h1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
